uart_cmd_responder: RTL and testbench
=====================================

Name: uart_cmd_responder

Overview:
Byte-level command responder that sits on the byte side of the team's UART transceiver and bridges a host to an 8-bit register bus.
- Parses host command frames from received bytes.
- Issues one register read or write per frame.
- Returns exactly one response byte per accepted command through the transmit handshake.
- Makes the FPGA the responding end of the host/UART link.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 115200, line baud rate
TIMEOUT_BITS, 40, inter-byte timeout in bit times; TIMEOUT_CLKS = (CLK_FREQ/BAUD_RATE)*TIMEOUT_BITS
ACK_TIMEOUT, 255, max cycles to wait for reg_ack after reg_req

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
rx_done  in  1  one-cycle pulse, byte received
rx_data  in  8  received byte, valid with rx_done
tx_busy  in  1  transmitter busy; rises the cycle after an accepted tx_start
tx_start  out  1  one-cycle pulse, send tx_data
tx_data  out  8  response byte, held stable until tx_busy falls
reg_req  out  1  one-cycle register access strobe
reg_we  out  1  1 = write, 0 = read; valid with reg_req
reg_addr  out  8  register address
reg_wdata  out  8  write data
reg_ack  in  1  access complete; may be high in the same cycle as reg_req
reg_rdata  in  8  read data, valid with reg_ack
busy  out  1  high whenever the state is not IDLE
err_opcode  out  1  pulse, unknown opcode
err_timeout  out  1  pulse, inter-byte or ack timeout
rx_overrun  out  1  pulse, byte dropped while not accepting

Behaviour:
- Reset (rst high, asynchronous):
  - All outputs go to 0; tx_data, reg_addr and reg_wdata go to 0x00.
  - State goes to IDLE and all counters clear.
  - A reset in mid-frame discards the partial frame. No response is sent.
- Frame formats:
  - Write: 0x57 ('W'), addr, data. Response is 0x4B ('K').
  - Read: 0x52 ('R'), addr. Response is the read data byte.
  - Any other first byte: response 0x45 ('E') and a one-cycle pulse on err_opcode.
- States: IDLE, GET_ADDR, GET_DATA, REG_REQ, REG_WAIT, SEND, SEND_WAIT.
- IDLE:
  - On rx_done with 'W' or 'R', latch the opcode and go to GET_ADDR.
  - On rx_done with any other byte, load 0x45 and go to SEND.
- GET_ADDR:
  - On rx_done, latch reg_addr.
  - For a write, go to GET_DATA. For a read, go to REG_REQ.
- GET_DATA:
  - On rx_done, latch reg_wdata and go to REG_REQ.
- Inter-byte timeout (GET_ADDR and GET_DATA only):
  - A counter clears on each rx_done.
  - When it reaches TIMEOUT_CLKS-1 with no byte, pulse err_timeout and return to IDLE. No response is sent.
- REG_REQ:
  - reg_req is high for exactly one cycle. reg_we, reg_addr and reg_wdata are stable from that cycle until reg_ack.
  - If reg_ack is high in this cycle, handle it as in REG_WAIT. Otherwise go to REG_WAIT.
- Latency: reg_req is asserted the cycle after the final rx_done of the frame.
- REG_WAIT:
  - On reg_ack, load tx_data (0x4B for a write, reg_rdata for a read) and go to SEND.
  - If ACK_TIMEOUT cycles pass without reg_ack, load 0x45, pulse err_timeout and go to SEND.
- SEND:
  - When tx_busy is 0, pulse tx_start for one cycle and go to SEND_WAIT.
  - When tx_busy is 1, hold in SEND.
- SEND_WAIT:
  - Set a seen-busy flag when tx_busy is 1.
  - Return to IDLE on the first cycle with the flag set and tx_busy at 0.
  - tx_start is never re-pulsed while in SEND_WAIT.
- Response latency: from reg_ack (cycle M) with tx_busy low, tx_start is high at M+1.
- rx_done while in REG_REQ, REG_WAIT, SEND or SEND_WAIT:
  - The byte is dropped and rx_overrun pulses in the same cycle.
  - State is unaffected.
- Simultaneous rx_done and a timeout expiry in the same cycle: the byte wins and the counter clears.
- Counters are wide enough for TIMEOUT_CLKS. Comparisons are unsigned.

Decomposition:
- Shared package uart_pkg holds:
  - Opcode constants OP_WRITE = 8'h57 and OP_READ = 8'h52.
  - Response constants RSP_OK = 8'h4B and RSP_ERR = 8'h45.
  - The state encoding localparams.
- No sub-module. The block is one FSM plus two counters.
- Top-level integration instantiates it beside uart_transceiver, with rx_done/rx_data and tx_start/tx_data/tx_busy wired directly.

Test Plan:
- Write: rx bytes 0x57, 0x10, 0xA5. Required response:
  - reg_req with reg_we=1, addr 0x10, wdata 0xA5 exactly one cycle after the third rx_done.
  - reg_ack in the same cycle, then tx_start with tx_data=0x4B one cycle later.
- Read: rx bytes 0x52, 0x22; reg_ack arrives 3 cycles after reg_req with reg_rdata=0x3C.
  - Required response: reg_we=0, then a single tx_start with tx_data=0x3C.
  - busy is held until tx_busy falls.
- Bad opcode: rx byte 0x41. Required response:
  - err_opcode pulses once and tx_data=0x45 is sent.
  - No reg_req is issued.
- Inter-byte timeout: 0x57, 0x10, then silence for TIMEOUT_CLKS. Required response:
  - err_timeout pulses and no tx_start occurs.
  - A following 0x52, 0x10 frame completes normally.
- Overrun/backpressure: hold tx_busy=1 during SEND and inject an rx_done. Required response:
  - rx_overrun pulses and the state is unchanged.
  - tx_start fires only after tx_busy=0.
- Reset mid-frame: assert rst after 0x57, 0x10. Required response:
  - All outputs go to 0 immediately and busy=0.
  - After release, the partial frame is not completed by a following 0x55 byte: err_opcode fires instead.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART command responder: frame opcodes, response
// bytes and the responder state encoding.
package uart_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_OK   = 8'h4B;
  localparam logic [7:0] RSP_ERR  = 8'h45;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_GET_ADDR  = 3'd1;
  localparam logic [2:0] ST_GET_DATA  = 3'd2;
  localparam logic [2:0] ST_REG_REQ   = 3'd3;
  localparam logic [2:0] ST_REG_WAIT  = 3'd4;
  localparam logic [2:0] ST_SEND      = 3'd5;
  localparam logic [2:0] ST_SEND_WAIT = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_GET_ADDR  = ST_GET_ADDR,
    S_GET_DATA  = ST_GET_DATA,
    S_REG_REQ   = ST_REG_REQ,
    S_REG_WAIT  = ST_REG_WAIT,
    S_SEND      = ST_SEND,
    S_SEND_WAIT = ST_SEND_WAIT
  } state_t;

  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OP_WRITE) || (b == OP_READ);
  endfunction

endpackage

// File: rtl/uart_cmd_responder.sv
// Host command responder: parses 'W'/'R' frames from the UART byte stream,
// performs one register access per frame and returns one response byte.
module uart_cmd_responder
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int TIMEOUT_BITS = 40,
  parameter int ACK_TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       reg_req,
  output logic       reg_we,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic       reg_ack,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       err_opcode,
  output logic       err_timeout,
  output logic       rx_overrun
);

  localparam int TIMEOUT_CLKS = (CLK_FREQ / BAUD_RATE) * TIMEOUT_BITS;
  localparam int TO_W         = $clog2(TIMEOUT_CLKS + 1);
  localparam int ACK_W        = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CLKS - 1);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

  state_t            r_state;
  logic [TO_W-1:0]   r_to_cnt;
  logic [ACK_W-1:0]  r_ack_cnt;
  logic [7:0]        r_tx_data;
  logic [7:0]        r_addr;
  logic [7:0]        r_wdata;
  logic              r_is_write;
  logic              r_seen_busy;
  logic              r_err_opcode;
  logic              r_err_timeout;

  state_t            w_state_next;
  logic [TO_W-1:0]   w_to_cnt_next;
  logic [ACK_W-1:0]  w_ack_cnt_next;
  logic [7:0]        w_tx_data_next;
  logic [7:0]        w_addr_next;
  logic [7:0]        w_wdata_next;
  logic              w_is_write_next;
  logic              w_seen_busy_next;
  logic              w_err_opcode_next;
  logic              w_err_timeout_next;
  logic              w_reg_req;
  logic              w_tx_start;
  logic              w_in_frame;
  logic              w_in_access;
  logic              w_in_send;
  logic              w_to_expired;
  logic [7:0]        w_ack_rsp;

  assign w_in_frame  = (r_state == S_GET_ADDR) || (r_state == S_GET_DATA);
  assign w_in_access = (r_state == S_REG_REQ) || (r_state == S_REG_WAIT);
  assign w_in_send   = (r_state == S_SEND) || (r_state == S_SEND_WAIT);

  // A byte arriving in the expiry cycle wins: the counter only expires when idle on the line.
  assign w_to_expired   = w_in_frame && !rx_done && (r_to_cnt == TO_LAST);
  assign w_to_cnt_next  = (w_in_frame && !rx_done) ? r_to_cnt + 1'b1 : '0;
  assign w_ack_cnt_next = w_in_access ? r_ack_cnt + 1'b1 : '0;
  assign w_ack_rsp      = r_is_write ? RSP_OK : reg_rdata;

  always_comb begin
    w_state_next       = r_state;
    w_tx_data_next     = r_tx_data;
    w_addr_next        = r_addr;
    w_wdata_next       = r_wdata;
    w_is_write_next    = r_is_write;
    w_seen_busy_next   = r_seen_busy;
    w_err_opcode_next  = 1'b0;
    w_err_timeout_next = 1'b0;
    w_reg_req          = 1'b0;
    w_tx_start         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (rx_done) begin
          if (is_opcode(rx_data)) begin
            w_is_write_next = (rx_data == OP_WRITE);
            w_state_next    = S_GET_ADDR;
          end else begin
            w_tx_data_next    = RSP_ERR;
            w_err_opcode_next = 1'b1;
            w_state_next      = S_SEND;
          end
        end
      end
      S_GET_ADDR: begin
        if (rx_done) begin
          w_addr_next  = rx_data;
          w_state_next = r_is_write ? S_GET_DATA : S_REG_REQ;
        end else if (w_to_expired) begin
          w_err_timeout_next = 1'b1;
          w_state_next       = S_IDLE;
        end
      end
      S_GET_DATA: begin
        if (rx_done) begin
          w_wdata_next = rx_data;
          w_state_next = S_REG_REQ;
        end else if (w_to_expired) begin
          w_err_timeout_next = 1'b1;
          w_state_next       = S_IDLE;
        end
      end
      S_REG_REQ: begin
        w_reg_req = 1'b1;
        if (reg_ack) begin
          w_tx_data_next = w_ack_rsp;
          w_state_next   = S_SEND;
        end else begin
          w_state_next = S_REG_WAIT;
        end
      end
      S_REG_WAIT: begin
        if (reg_ack) begin
          w_tx_data_next = w_ack_rsp;
          w_state_next   = S_SEND;
        end else if (r_ack_cnt == ACK_LAST) begin
          w_tx_data_next     = RSP_ERR;
          w_err_timeout_next = 1'b1;
          w_state_next       = S_SEND;
        end
      end
      S_SEND: begin
        if (!tx_busy) begin
          w_tx_start       = 1'b1;
          w_seen_busy_next = 1'b0;
          w_state_next     = S_SEND_WAIT;
        end
      end
      S_SEND_WAIT: begin
        // Wait for the transmitter to take the byte and finish before re-arming.
        if (tx_busy) begin
          w_seen_busy_next = 1'b1;
        end else if (r_seen_busy) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_to_cnt      <= '0;
      r_ack_cnt     <= '0;
      r_tx_data     <= 8'h00;
      r_addr        <= 8'h00;
      r_wdata       <= 8'h00;
      r_is_write    <= 1'b0;
      r_seen_busy   <= 1'b0;
      r_err_opcode  <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_to_cnt      <= w_to_cnt_next;
      r_ack_cnt     <= w_ack_cnt_next;
      r_tx_data     <= w_tx_data_next;
      r_addr        <= w_addr_next;
      r_wdata       <= w_wdata_next;
      r_is_write    <= w_is_write_next;
      r_seen_busy   <= w_seen_busy_next;
      r_err_opcode  <= w_err_opcode_next;
      r_err_timeout <= w_err_timeout_next;
    end
  end

  assign tx_start    = w_tx_start;
  assign tx_data     = r_tx_data;
  assign reg_req     = w_reg_req;
  assign reg_we      = r_is_write;
  assign reg_addr    = r_addr;
  assign reg_wdata   = r_wdata;
  assign busy        = (r_state != S_IDLE);
  assign err_opcode  = r_err_opcode;
  assign err_timeout = r_err_timeout;
  assign rx_overrun  = rx_done && (w_in_access || w_in_send);

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: frame-level model plus per-cycle checker.
module tb_uart_cmd_responder;

  localparam int T_CLKS = 40;   // (1_000_000 / 100_000) * 4
  localparam int ACK_TO = 8;
  localparam int TX_LEN = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       reg_req;
  logic       reg_we;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_ack;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       err_opcode;
  logic       err_timeout;
  logic       rx_overrun;

  uart_cmd_responder #(
    .CLK_FREQ    (1_000_000),
    .BAUD_RATE   (100_000),
    .TIMEOUT_BITS(4),
    .ACK_TIMEOUT (ACK_TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_done    (rx_done),
    .rx_data    (rx_data),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .reg_req    (reg_req),
    .reg_we     (reg_we),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .reg_ack    (reg_ack),
    .reg_rdata  (reg_rdata),
    .busy       (busy),
    .err_opcode (err_opcode),
    .err_timeout(err_timeout),
    .rx_overrun (rx_overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- transmitter and register-bus responders ----------------
  logic tx_busy_m = 1'b0;
  logic tx_hold   = 1'b0;
  assign tx_busy = tx_busy_m | tx_hold;

  initial forever begin
    @(negedge clk);
    if (!rst && tx_start && !tx_busy) begin
      @(posedge clk); #1 tx_busy_m = 1'b1;
      repeat (TX_LEN) @(posedge clk);
      #1 tx_busy_m = 1'b0;
    end
  end

  logic [7:0] s_mem [256];
  logic       ack_en    = 1'b1;
  int         ack_delay = 0;
  logic       ack_pulse = 1'b0;
  assign reg_ack   = ack_en & (((ack_delay == 0) & reg_req) | ack_pulse);
  assign reg_rdata = s_mem[reg_addr];

  initial begin
    for (int i = 0; i < 256; i++) s_mem[i] = 8'h00;
    s_mem[8'h22] = 8'h3C;
    forever begin
      @(negedge clk);
      if (!rst && reg_ack && reg_we) s_mem[reg_addr] = reg_wdata;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst && reg_req && ack_en && ack_delay > 0) begin
      repeat (ack_delay) @(posedge clk);
      #1 ack_pulse = 1'b1;
      @(posedge clk);
      #1 ack_pulse = 1'b0;
    end
  end

  // ---------------- frame-level model ----------------
  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         cyc;
  } acc_t;

  logic [7:0] m_mem [256];
  logic [7:0] m_frame [$];
  acc_t       exp_acc [$];
  logic [7:0] exp_tx [$];
  int         exp_err_op = 0;
  int         exp_err_to = 0;
  int         exp_ovr    = 0;
  logic       m_ack_en   = 1'b1;

  task automatic model_rx(input logic [7:0] b, input int c);
    m_frame.push_back(b);
    if (m_frame[0] != 8'h57 && m_frame[0] != 8'h52) begin
      exp_tx.push_back(8'h45);
      exp_err_op++;
      m_frame.delete();
    end else if (m_frame[0] == 8'h57 && m_frame.size() == 3) begin
      exp_acc.push_back('{1'b1, m_frame[1], m_frame[2], c + 1});
      if (m_ack_en) begin
        m_mem[m_frame[1]] = m_frame[2];
        exp_tx.push_back(8'h4B);
      end else begin
        exp_tx.push_back(8'h45);
        exp_err_to++;
      end
      m_frame.delete();
    end else if (m_frame[0] == 8'h52 && m_frame.size() == 2) begin
      exp_acc.push_back('{1'b0, m_frame[1], 8'h00, c + 1});
      if (m_ack_en) begin
        exp_tx.push_back(m_mem[m_frame[1]]);
      end else begin
        exp_tx.push_back(8'h45);
        exp_err_to++;
      end
      m_frame.delete();
    end
  endtask

  // ---------------- per-cycle compare process ----------------
  int n_req = 0, n_tx = 0, n_err_op = 0, n_err_to = 0, n_ovr = 0;
  int t_req = -1, t_ack = -1, t_txs = -1, t_err_to = -1, t_ovr = -1;
  int t_txb_fall = -1, t_busy_fall = -1;
  logic       last_we;
  logic [7:0] last_addr, last_wdata, last_tx;

  initial begin
    logic prev_txb, prev_busy;
    acc_t e;
    logic [7:0] et;
    prev_txb  = 1'b0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("reset_outputs_zero",
              {tx_start, tx_data, reg_req, reg_we, reg_addr, reg_wdata,
               busy, err_opcode, err_timeout, rx_overrun}, '0);
      end else begin
        if (reg_req) begin
          n_req++; t_req = cyc;
          last_we = reg_we; last_addr = reg_addr; last_wdata = reg_wdata;
          check("reg_req_expected", exp_acc.size() > 0, 1);
          if (exp_acc.size() > 0) begin
            e = exp_acc.pop_front();
            check("reg_we", reg_we, e.we);
            check("reg_addr", reg_addr, e.addr);
            if (e.we) check("reg_wdata", reg_wdata, e.wdata);
            check("reg_req_cycle", cyc, e.cyc);
          end
        end
        if (reg_ack) t_ack = cyc;
        if (tx_start) begin
          n_tx++; t_txs = cyc; last_tx = tx_data;
          check("tx_start_while_tx_busy", tx_busy, 0);
          check("tx_start_expected", exp_tx.size() > 0, 1);
          if (exp_tx.size() > 0) begin
            et = exp_tx.pop_front();
            check("tx_data", tx_data, et);
          end
        end
        if (err_opcode) begin
          n_err_op++;
          check("err_opcode_expected", exp_err_op > 0, 1);
          if (exp_err_op > 0) exp_err_op--;
        end
        if (err_timeout) begin
          n_err_to++; t_err_to = cyc;
          check("err_timeout_expected", exp_err_to > 0, 1);
          if (exp_err_to > 0) exp_err_to--;
        end
        if (rx_overrun) begin
          n_ovr++; t_ovr = cyc;
          check("rx_overrun_expected", exp_ovr > 0, 1);
          if (exp_ovr > 0) exp_ovr--;
        end
        if (prev_txb && !tx_busy) t_txb_fall = cyc;
        if (prev_busy && !busy) t_busy_fall = cyc;
      end
      prev_txb  = tx_busy;
      prev_busy = busy;
    end
  end

  // ---------------- stimulus helpers ----------------
  int last_rx_cyc = -1;

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge clk);
    @(posedge clk);
    #1 rx_data = b; rx_done = 1'b1;
    last_rx_cyc = cyc;
    model_rx(b, cyc);
    @(posedge clk);
    #1 rx_done = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || tx_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_completes"}, busy || tx_busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int r, n0, q0, e0, e1, t_inj, t_rel;
    rst = 1'b1; rx_done = 1'b0; rx_data = 8'h00;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    m_mem[8'h22] = 8'h3C;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Write 0x10 <- 0xA5, ack in the request cycle
    send_byte(8'h57, 2); send_byte(8'h10, 2); send_byte(8'hA5, 2);
    r = last_rx_cyc;
    wait_idle("write", 60);
    check("wr_req_latency", t_req, r + 1);
    check("wr_ack_same_cycle", t_ack, t_req);
    check("wr_tx_latency", t_txs, r + 2);
    check("wr_tx_data", last_tx, 8'h4B);
    check("wr_addr", last_addr, 8'h10);
    check("wr_wdata", last_wdata, 8'hA5);
    check("wr_we", last_we, 1);
    check("wr_slave_mem", s_mem[8'h10], 8'hA5);

    // Read 0x22, ack three cycles after the request
    ack_delay = 3; n0 = n_tx;
    send_byte(8'h52, 2); send_byte(8'h22, 2);
    r = last_rx_cyc;
    wait_idle("read", 60);
    check("rd_req_latency", t_req, r + 1);
    check("rd_ack_delay", t_ack, t_req + 3);
    check("rd_tx_latency", t_txs, t_ack + 1);
    check("rd_tx_data", last_tx, 8'h3C);
    check("rd_we", last_we, 0);
    check("rd_single_tx", n_tx, n0 + 1);
    check("rd_busy_until_tx_idle", t_busy_fall, t_txb_fall + 1);

    // Unknown opcode
    ack_delay = 0; n0 = n_tx; q0 = n_req; e0 = n_err_op;
    send_byte(8'h41, 2);
    wait_idle("bad_opcode", 60);
    check("bad_op_no_req", n_req, q0);
    check("bad_op_err_pulse", n_err_op, e0 + 1);
    check("bad_op_tx_data", last_tx, 8'h45);
    check("bad_op_single_tx", n_tx, n0 + 1);

    // Inter-byte timeout with no response
    n0 = n_tx; e0 = n_err_to;
    send_byte(8'h57, 2); send_byte(8'h10, 2);
    r = last_rx_cyc;
    m_frame.delete(); exp_err_to++;
    repeat (T_CLKS + 5) @(posedge clk);
    #1;
    check("to_pulse_cycle", t_err_to, r + T_CLKS + 1);
    check("to_pulse_count", n_err_to, e0 + 1);
    check("to_no_tx", n_tx, n0);
    check("to_back_idle", busy, 0);

    // Bytes landing exactly in the expiry cycle still count
    e1 = n_err_to;
    send_byte(8'h57, 2); send_byte(8'h33, T_CLKS - 2); send_byte(8'h77, T_CLKS - 2);
    wait_idle("late_bytes", 60);
    check("late_no_timeout", n_err_to, e1);
    check("late_tx_data", last_tx, 8'h4B);
    check("late_addr", last_addr, 8'h33);
    check("late_wdata", last_wdata, 8'h77);

    // Following read frame completes normally
    send_byte(8'h52, 2); send_byte(8'h10, 2);
    wait_idle("read_after_to", 60);
    check("rd2_tx_data", last_tx, 8'hA5);
    check("rd2_addr", last_addr, 8'h10);

    // Backpressure and overrun while holding in SEND
    tx_hold = 1'b1; n0 = n_tx;
    send_byte(8'h52, 2); send_byte(8'h22, 2);
    repeat (6) @(posedge clk);
    #1;
    check("ovr_hold_busy", busy, 1);
    check("ovr_no_tx_yet", n_tx, n0);
    exp_ovr++;
    @(posedge clk);
    #1 rx_data = 8'hEE; rx_done = 1'b1; t_inj = cyc;
    @(posedge clk);
    #1 rx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("ovr_pulse_cycle", t_ovr, t_inj);
    check("ovr_state_kept", busy, 1);
    check("ovr_still_no_tx", n_tx, n0);
    @(posedge clk);
    #1 tx_hold = 1'b0; t_rel = cyc;
    wait_idle("overrun", 60);
    check("ovr_tx_on_release", t_txs, t_rel);
    check("ovr_tx_data", last_tx, 8'h3C);

    // Register bus never acknowledges
    ack_en = 1'b0; m_ack_en = 1'b0;
    send_byte(8'h52, 2); send_byte(8'h40, 2);
    wait_idle("ack_timeout", 80);
    check("ackto_tx_cycle", t_txs, t_req + ACK_TO);
    check("ackto_err_cycle", t_err_to, t_req + ACK_TO);
    check("ackto_tx_data", last_tx, 8'h45);
    ack_en = 1'b1; m_ack_en = 1'b1;

    // Reset in mid-frame discards the partial frame
    send_byte(8'h57, 2); send_byte(8'h10, 2);
    @(posedge clk);
    #1 rst = 1'b1;
    m_frame.delete();
    #1;
    check("rst_async_outputs",
          {tx_start, tx_data, reg_req, reg_we, reg_addr, reg_wdata,
           err_opcode, err_timeout, rx_overrun}, '0);
    check("rst_async_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    e0 = n_err_op; q0 = n_req;
    send_byte(8'h55, 2);
    wait_idle("after_reset", 60);
    check("rst_err_opcode", n_err_op, e0 + 1);
    check("rst_tx_data", last_tx, 8'h45);
    check("rst_no_req", n_req, q0);

    // Nothing left outstanding in the model
    repeat (3) @(posedge clk);
    #1;
    check("drain_tx", exp_tx.size(), 0);
    check("drain_acc", exp_acc.size(), 0);
    check("drain_err_opcode", exp_err_op, 0);
    check("drain_err_timeout", exp_err_to, 0);
    check("drain_overrun", exp_ovr, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
